teclado_acumulador: RTL and testbench
=====================================

Name: teclado_acumulador

Overview:
Downstream consumer of the 4x4 keypad scan driver. Takes the driver's 5-bit key code and its per-scan "key seen" strobe, and detects individual press/release events. Accumulates up to N_DIGITOS decimal digits as packed BCD and handles edit/command keys (backspace, clear, enter). Delivers a latched multi-digit value with a one-cycle valid pulse to the control logic.

Parameters:
N_DIGITOS, 4, max digits held in the entry buffer (1..8)
CICLOS_SUELTA, 8, consecutive clk cycles without cambio_digito that mark a key as released (must exceed the 4-cycle column scan period)
CICLOS_TIMEOUT, 500, idle cycles before buffer auto-clear (used only with ENTRY_TIMEOUT_EN)

Ports:
clk  input  1  system clock, same 100 Hz domain as the keypad driver
rst_n  input  1  synchronous reset, active-low
digito  input  5  key code from driver: 0-9 digits, 0xA-0xF function keys, 16/17 = none/invalid
cambio_digito  input  1  high on cycles where the driver sees a pressed key; pulses once per scan while held
buffer_bcd  output  4*N_DIGITOS  live entry buffer, newest digit in bits [3:0]
n_digitos  output  4  number of valid digits in buffer_bcd (0..N_DIGITOS)
valor  output  4*N_DIGITOS  value latched on enter
valor_listo  output  1  one-cycle pulse when valor is updated
tecla_func  output  1  one-cycle pulse on B/C/D press
codigo_func  output  2  1=B, 2=C, 3=D; valid while tecla_func=1, holds last value otherwise
desborde  output  1  one-cycle pulse when a digit is rejected because the buffer is full
timeout  output  1  one-cycle pulse on idle auto-clear; constant 0 without ENTRY_TIMEOUT_EN

Behaviour:
- Reset: rst_n sampled low at posedge clk. All outputs 0, buffer_bcd=0, n_digitos=0, valor=0, codigo_func=0, state ESPERA, counters 0. Reset overrides every other event, including mid-press. After reset the block waits for a fresh press.
- FSM, two states:
  - ESPERA: when cambio_digito=1 and digito<=15, the key is accepted at that edge, its action is applied at the same edge, and the state goes to PRESIONADA with the release counter at 0. If digito is 16 or 17, the strobe is ignored and the state stays ESPERA.
  - PRESIONADA: cambio_digito=1 clears the release counter. Otherwise the counter increments. When it reaches CICLOS_SUELTA-1 with cambio_digito=0, the state returns to ESPERA. Code changes while in PRESIONADA (rollover) are ignored.
- Exactly one action per press, however long the key is held. Results are visible the cycle after the accepting edge.
- Key actions:
  - 0-9: if n_digitos<N_DIGITOS, buffer_bcd <= {buffer_bcd shifted left 4, digit} and n_digitos+1. If full, the buffer is unchanged and desborde pulses.
  - 0xA (backspace): if n_digitos>0, buffer_bcd shifted right 4 (zero fill) and n_digitos-1. If empty, no-op.
  - 0xB/0xC/0xD: tecla_func pulses; codigo_func = 1/2/3. Buffer unchanged.
  - 0xE (*, clear): buffer_bcd=0, n_digitos=0. No pulse.
  - 0xF (#, enter): if n_digitos>0, valor<=buffer_bcd, valor_listo pulses, and buffer/n_digitos clear at the same edge. If n_digitos=0, ignored with no pulse.
- All pulses are exactly one cycle wide, and at most one pulse fires per accepted press.
- Leading zeros count as digits ("0","0" gives n_digitos=2).

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: an idle counter runs while state=ESPERA and n_digitos>0, and resets on any accepted key or when n_digitos=0. When it reaches CICLOS_TIMEOUT-1, buffer_bcd and n_digitos clear and timeout pulses for one cycle. If a key is accepted on that same edge, the key wins: no clear, no pulse, counter reset.
- Not defined: no counter, the buffer persists indefinitely, and timeout is tied to 0.

Test Plan:
- Reset then press 1,2,3 (each held 12 cycles as scan-style strobes every 4th cycle, 10 cycles released) -> buffer_bcd=0x0123, n_digitos=3, no duplicate digits.
- Type 4,5 then # -> valor=0x0045, valor_listo high exactly 1 cycle, then buffer_bcd=0, n_digitos=0. A # on empty buffer -> no pulse.
- Type 9,8,7,6,5 with N_DIGITOS=4 -> buffer_bcd=0x9876, desborde pulses once on the 5. Then A -> 0x0987, n=3. Then * -> 0, n=0.
- Press C -> tecla_func 1 cycle, codigo_func=2, buffer unchanged. Strobe with digito=16 in ESPERA -> no action.
- Hold 7, assert rst_n=0 for 1 cycle mid-hold while strobes continue -> outputs 0. The 7 is re-accepted only after a release gap of CICLOS_SUELTA cycles and a new press.
- With ENTRY_TIMEOUT_EN and CICLOS_TIMEOUT=20: type 3, idle 20 cycles -> timeout pulse, n_digitos=0. A key accepted on the expiry cycle -> no timeout.

Source files
------------

// File: rtl/teclado_acumulador.sv
// Keypad entry accumulator: detects single press/release events from the scan driver and
// builds a packed-BCD entry buffer with backspace/clear/enter. Optional macro: ENTRY_TIMEOUT_EN.
module teclado_acumulador #(
    parameter int N_DIGITOS      = 4,
    parameter int CICLOS_SUELTA  = 8,
    parameter int CICLOS_TIMEOUT = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             digito,
    input  logic                   cambio_digito,
    output logic [4*N_DIGITOS-1:0] buffer_bcd,
    output logic [3:0]             n_digitos,
    output logic [4*N_DIGITOS-1:0] valor,
    output logic                   valor_listo,
    output logic                   tecla_func,
    output logic [1:0]             codigo_func,
    output logic                   desborde,
    output logic                   timeout
);

    localparam int         BW    = 4 * N_DIGITOS;
    localparam int         SW    = $clog2(CICLOS_SUELTA + 1);
    localparam logic [3:0] N_MAX = 4'(N_DIGITOS);

    if (N_DIGITOS < 1 || N_DIGITOS > 8 || CICLOS_SUELTA < 5 || CICLOS_TIMEOUT < 2) begin : g_param_invalido
        $error("teclado_acumulador: parameter out of range");
    end

    typedef enum logic {ESPERA, PRESIONADA} estado_t;

    estado_t         estado, estado_sig;
    logic [SW-1:0]   cnt_suelta, cnt_suelta_sig;
    logic            armado, armado_sig;
    logic            acepta;
    logic [3:0]      tecla;

    assign tecla = digito[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= ESPERA;
            cnt_suelta <= '0;
            armado     <= 1'b0;
        end else begin
            estado     <= estado_sig;
            cnt_suelta <= cnt_suelta_sig;
            armado     <= armado_sig;
        end
    end

    // After reset a key may still be held; disarm until a full release gap has been seen.
    always_comb begin
        estado_sig     = estado;
        cnt_suelta_sig = cnt_suelta;
        armado_sig     = armado;
        acepta         = 1'b0;
        case (estado)
            ESPERA: begin
                if (!armado) begin
                    if (cambio_digito) begin
                        cnt_suelta_sig = '0;
                    end else if (cnt_suelta == SW'(CICLOS_SUELTA - 1)) begin
                        armado_sig     = 1'b1;
                        cnt_suelta_sig = '0;
                    end else begin
                        cnt_suelta_sig = cnt_suelta + SW'(1);
                    end
                end else if (cambio_digito && !digito[4]) begin
                    acepta         = 1'b1;
                    estado_sig     = PRESIONADA;
                    cnt_suelta_sig = '0;
                end
            end
            PRESIONADA: begin
                if (cambio_digito) begin
                    cnt_suelta_sig = '0;
                end else if (cnt_suelta == SW'(CICLOS_SUELTA - 1)) begin
                    estado_sig     = ESPERA;
                    cnt_suelta_sig = '0;
                end else begin
                    cnt_suelta_sig = cnt_suelta + SW'(1);
                end
            end
            default: estado_sig = ESPERA;
        endcase
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(CICLOS_TIMEOUT + 1);
    logic [TW-1:0] cnt_idle;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer_bcd  <= '0;
            n_digitos   <= '0;
            valor       <= '0;
            valor_listo <= 1'b0;
            tecla_func  <= 1'b0;
            codigo_func <= '0;
            desborde    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timeout     <= 1'b0;
            cnt_idle    <= '0;
`endif
        end else begin
            valor_listo <= 1'b0;
            tecla_func  <= 1'b0;
            desborde    <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
            if (acepta) begin
                if (tecla <= 4'd9) begin
                    if (n_digitos < N_MAX) begin
                        buffer_bcd <= (buffer_bcd << 4) | BW'(tecla);
                        n_digitos  <= n_digitos + 4'd1;
                    end else begin
                        desborde <= 1'b1;
                    end
                end else begin
                    case (tecla)
                        4'hA: if (n_digitos != 4'd0) begin
                            buffer_bcd <= buffer_bcd >> 4;
                            n_digitos  <= n_digitos - 4'd1;
                        end
                        4'hB, 4'hC, 4'hD: begin
                            tecla_func  <= 1'b1;
                            codigo_func <= 2'(tecla - 4'hA);
                        end
                        4'hE: begin
                            buffer_bcd <= '0;
                            n_digitos  <= '0;
                        end
                        default: if (n_digitos != 4'd0) begin
                            valor       <= buffer_bcd;
                            valor_listo <= 1'b1;
                            buffer_bcd  <= '0;
                            n_digitos   <= '0;
                        end
                    endcase
                end
            end
`ifdef ENTRY_TIMEOUT_EN
            // An accepted key on the expiry edge wins over the auto-clear.
            if (acepta || n_digitos == 4'd0) begin
                cnt_idle <= '0;
            end else if (estado == ESPERA) begin
                if (cnt_idle == TW'(CICLOS_TIMEOUT - 1)) begin
                    buffer_bcd <= '0;
                    n_digitos  <= '0;
                    timeout    <= 1'b1;
                    cnt_idle   <= '0;
                end else begin
                    cnt_idle <= cnt_idle + TW'(1);
                end
            end
`endif
        end
    end

`ifndef ENTRY_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_teclado_acumulador.sv
// Bench for teclado_acumulador: press-level vector table, hand sequences, and random cycles
// checked every clock against a digit-queue reference model.
module tb_teclado_acumulador;

    localparam int ND = 4;
    localparam int CS = 8;
    localparam int CT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  digito = 5'd16;
    logic        cambio_digito = 1'b0;
    logic [15:0] buffer_bcd, valor;
    logic [3:0]  n_digitos;
    logic        valor_listo, tecla_func, desborde, timeout;
    logic [1:0]  codigo_func;

    teclado_acumulador #(.N_DIGITOS(ND), .CICLOS_SUELTA(CS), .CICLOS_TIMEOUT(CT)) dut (
        .clk(clk), .rst_n(rst_n), .digito(digito), .cambio_digito(cambio_digito),
        .buffer_bcd(buffer_bcd), .n_digitos(n_digitos), .valor(valor),
        .valor_listo(valor_listo), .tecla_func(tecla_func), .codigo_func(codigo_func),
        .desborde(desborde), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: digits kept oldest-first in a queue.
    int          m_digs[$];
    bit          m_pressed;
    int          m_quiet, m_idle;
    logic [15:0] m_valor;
    logic        m_listo, m_func, m_desb, m_tout;
    logic [1:0]  m_cod;

    function automatic logic [15:0] m_buf();
        logic [15:0] b = 16'h0;
        foreach (m_digs[i]) b = (b << 4) | 16'(m_digs[i]);
        return b;
    endfunction

    function automatic logic [63:0] dut_bus();
        return {22'b0, buffer_bcd, n_digitos, valor, valor_listo, tecla_func, codigo_func, desborde, timeout};
    endfunction

    function automatic logic [63:0] model_bus();
        return {22'b0, m_buf(), 4'(m_digs.size()), m_valor, m_listo, m_func, m_cod, m_desb, m_tout};
    endfunction

    task automatic model_step(input logic r, input logic [4:0] d, input logic c);
        bit acc, was_pressed;
        int n0;
        m_listo = 0; m_func = 0; m_desb = 0; m_tout = 0;
        if (!r) begin
            m_pressed = 1; m_quiet = 0; m_digs.delete(); m_valor = 0; m_cod = 0; m_idle = 0;
            return;
        end
        was_pressed = m_pressed;
        n0  = m_digs.size();
        acc = !m_pressed && c && (d <= 15);
        m_quiet = c ? 0 : m_quiet + 1;
        if (m_pressed && m_quiet >= CS) m_pressed = 0;
        if (acc) begin
            m_pressed = 1;
            if (d <= 9) begin
                if (n0 < ND) m_digs.push_back(int'(d)); else m_desb = 1;
            end else if (d == 10) begin
                if (n0 > 0) void'(m_digs.pop_back());
            end else if (d <= 13) begin
                m_func = 1; m_cod = 2'(d - 10);
            end else if (d == 14) begin
                m_digs.delete();
            end else if (n0 > 0) begin
                m_valor = m_buf(); m_listo = 1; m_digs.delete();
            end
        end
`ifdef ENTRY_TIMEOUT_EN
        if (acc || n0 == 0) m_idle = 0;
        else if (!was_pressed) begin
            if (m_idle == CT - 1) begin
                m_digs.delete(); m_tout = 1; m_idle = 0;
            end else m_idle++;
        end
`endif
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, step the model, compare everything.
    task automatic cyc(input logic r, input logic [4:0] d, input logic c);
        rst_n = r; digito = d; cambio_digito = c;
        @(posedge clk);
        model_step(r, d, c);
        #1;
        chk("cycle", dut_bus(), model_bus());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 5'd16, 1'b0);
    endtask

    // Scan-style press: strobes every 4th cycle for 12 cycles, then 10 released cycles.
    task automatic press(input logic [4:0] k, output logic [2:0] pul);
        pul = 3'b000;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, k, (i % 4) == 0);
            if (i == 0) pul = {valor_listo, tecla_func, desborde};
        end
        idle(10);
    endtask

    typedef struct {
        logic [4:0]  k;
        logic [15:0] b;
        logic [3:0]  n;
        logic [15:0] v;
        logic [2:0]  p;   // {valor_listo, tecla_func, desborde}
        logic [1:0]  cod;
    } vec_t;

    vec_t tab[24];
    logic [2:0] pul;
    bit seen;

    initial begin
        tab[0]  = '{5'h1, 16'h0001, 4'd1, 16'h0000, 3'b000, 2'd0};
        tab[1]  = '{5'h2, 16'h0012, 4'd2, 16'h0000, 3'b000, 2'd0};
        tab[2]  = '{5'h3, 16'h0123, 4'd3, 16'h0000, 3'b000, 2'd0};
        tab[3]  = '{5'hF, 16'h0000, 4'd0, 16'h0123, 3'b100, 2'd0};
        tab[4]  = '{5'h4, 16'h0004, 4'd1, 16'h0123, 3'b000, 2'd0};
        tab[5]  = '{5'h5, 16'h0045, 4'd2, 16'h0123, 3'b000, 2'd0};
        tab[6]  = '{5'hF, 16'h0000, 4'd0, 16'h0045, 3'b100, 2'd0};
        tab[7]  = '{5'hF, 16'h0000, 4'd0, 16'h0045, 3'b000, 2'd0};
        tab[8]  = '{5'h9, 16'h0009, 4'd1, 16'h0045, 3'b000, 2'd0};
        tab[9]  = '{5'h8, 16'h0098, 4'd2, 16'h0045, 3'b000, 2'd0};
        tab[10] = '{5'h7, 16'h0987, 4'd3, 16'h0045, 3'b000, 2'd0};
        tab[11] = '{5'h6, 16'h9876, 4'd4, 16'h0045, 3'b000, 2'd0};
        tab[12] = '{5'h5, 16'h9876, 4'd4, 16'h0045, 3'b001, 2'd0};
        tab[13] = '{5'hA, 16'h0987, 4'd3, 16'h0045, 3'b000, 2'd0};
        tab[14] = '{5'hE, 16'h0000, 4'd0, 16'h0045, 3'b000, 2'd0};
        tab[15] = '{5'hA, 16'h0000, 4'd0, 16'h0045, 3'b000, 2'd0};
        tab[16] = '{5'hC, 16'h0000, 4'd0, 16'h0045, 3'b010, 2'd2};
        tab[17] = '{5'h3, 16'h0003, 4'd1, 16'h0045, 3'b000, 2'd2};
        tab[18] = '{5'hB, 16'h0003, 4'd1, 16'h0045, 3'b010, 2'd1};
        tab[19] = '{5'hD, 16'h0003, 4'd1, 16'h0045, 3'b010, 2'd3};
        tab[20] = '{5'hE, 16'h0000, 4'd0, 16'h0045, 3'b000, 2'd3};
        tab[21] = '{5'h0, 16'h0000, 4'd1, 16'h0045, 3'b000, 2'd3};
        tab[22] = '{5'h0, 16'h0000, 4'd2, 16'h0045, 3'b000, 2'd3};
        tab[23] = '{5'hF, 16'h0000, 4'd0, 16'h0000, 3'b100, 2'd3};

        // Reset and the post-reset release gap.
        cyc(1'b0, 5'd16, 1'b0);
        cyc(1'b0, 5'd16, 1'b0);
        chk("reset state", dut_bus(), 64'h0);
        idle(10);

        foreach (tab[i]) begin
            press(tab[i].k, pul);
            chk($sformatf("vec%0d buf", i), 64'(buffer_bcd), 64'(tab[i].b));
            chk($sformatf("vec%0d n", i), 64'(n_digitos), 64'(tab[i].n));
            chk($sformatf("vec%0d valor", i), 64'(valor), 64'(tab[i].v));
            chk($sformatf("vec%0d pulses", i), 64'(pul), 64'(tab[i].p));
            chk($sformatf("vec%0d codigo", i), 64'(codigo_func), 64'(tab[i].cod));
        end

        // Strobes carrying none/invalid codes are ignored, then a real key is taken.
        cyc(1'b1, 5'd16, 1'b1); cyc(1'b1, 5'd17, 1'b1); idle(3);
        chk("invalid code n", 64'(n_digitos), 64'd0);
        press(5'h5, pul);
        chk("after invalid buf", 64'(buffer_bcd), 64'h0005);

        // Rollover: code changes while held are not new presses.
        cyc(1'b1, 5'h1, 1'b1);
        for (int i = 1; i < 12; i++) cyc(1'b1, 5'h2, (i % 4) == 0);
        idle(10);
        chk("rollover buf", 64'(buffer_bcd), 64'h0051);

        // Release threshold: 7 quiet cycles keep the key held, 8 release it.
        cyc(1'b1, 5'h3, 1'b1);
        idle(CS - 1);
        cyc(1'b1, 5'h4, 1'b1);
        idle(CS);
        cyc(1'b1, 5'h6, 1'b1);
        idle(10);
        chk("release gap buf", 64'(buffer_bcd), 64'h5136);
        chk("release gap n", 64'(n_digitos), 64'd4);

        // Reset in the middle of a held key.
        press(5'hE, pul);
        for (int i = 0; i < 8; i++) cyc(1'b1, 5'h7, (i % 4) == 0);
        chk("held 7 buf", 64'(buffer_bcd), 64'h0007);
        cyc(1'b0, 5'h7, 1'b1);
        chk("mid-hold reset", dut_bus(), 64'h0);
        for (int i = 1; i < 20; i++) cyc(1'b1, 5'h7, (i % 4) == 0);
        chk("no re-accept while held", 64'(n_digitos), 64'd0);
        idle(10);
        press(5'h7, pul);
        chk("re-accept 7", 64'(buffer_bcd), 64'h0007);

`ifdef ENTRY_TIMEOUT_EN
        press(5'hE, pul);
        press(5'h3, pul);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1'b1, 5'd16, 1'b0);
            if (timeout) seen = 1;
        end
        chk("timeout pulse", 64'(seen), 64'd1);
        chk("timeout n", 64'(n_digitos), 64'd0);
        press(5'h3, pul);
        for (int i = 0; i < 40 && m_idle != CT - 1; i++) cyc(1'b1, 5'd16, 1'b0);
        chk("at expiry", 64'(m_idle), 64'(CT - 1));
        cyc(1'b1, 5'h4, 1'b1);
        chk("key wins timeout", 64'(timeout), 64'd0);
        chk("key wins buf", 64'(buffer_bcd), 64'h0034);
        idle(10);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(199) != 0), 5'($urandom_range(17)), 1'($urandom_range(3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
